// File: rtl/axi4_burst_mem_model.sv
// rtl/axi4_burst_mem_model.sv - behavioural AXI4 burst memory slave standing in for the DDR2 subsystem
//
// Purpose: full AXI4 slave backed by a word array. It supports INCR/FIXED/WRAP
// bursts, narrow transfers through wstrb, ID echo, a programmable read latency
// and a post-reset calibration delay. The read and write channels are
// independent, and each channel holds one transaction at a time.
//
// Ports:
//   i_clk_axi, i_rstn_axi            clock, synchronous active-low reset
//   o_calib_done                     model ready; address channels closed while low
//   i_aw* / o_awready                write address channel
//   i_w*  / o_wready                 write data channel
//   o_b*  / i_bready                 write response channel
//   i_ar* / o_arready                read address channel
//   o_r*  / i_rready                 read data channel
module axi4_burst_mem_model #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 27,
  parameter int MEM_AW    = 16,
  parameter int ID_W      = 1,
  parameter int RD_LAT    = 4,
  parameter int CALIB_CYC = 16
) (
  input  logic                i_clk_axi,
  input  logic                i_rstn_axi,
  output logic                o_calib_done,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic [ID_W-1:0]     i_awid,
  input  logic [7:0]          i_awlen,
  input  logic [2:0]          i_awsize,
  input  logic [1:0]          i_awburst,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wlast,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [ID_W-1:0]     o_bid,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [ID_W-1:0]     i_arid,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [ID_W-1:0]     o_rid,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic                o_rvalid,
  input  logic                i_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int CAL_W  = $clog2(CALIB_CYC + 1);
  localparam int LAT_W  = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  // Contents are left unreset so that uninitialised reads show up as X.
  logic [DATA_W-1:0] r_mem [0:(1<<MEM_AW)-1];

  function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (int'(size) > LSB) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  // Illegal WRAP lengths fall back to INCR stepping. Those bursts are already
  // errored, so neither memory nor read data depend on the resulting address.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [7:0] len, input logic [2:0] size,
                                                   input logic [1:0] burst);
    logic [ADDR_W-1:0] step, incr, span;
    step = ADDR_W'(1) << size;
    incr = (addr & ~(step - ADDR_W'(1))) + step;
    span = ADDR_W'({1'b0, len} + 9'd1) << size;
    if (burst == 2'b00)
      return addr;
    else if ((burst == 2'b10) && !burst_err(len, size, burst))
      return (addr & ~(span - ADDR_W'(1))) | (incr & (span - ADDR_W'(1)));
    else
      return incr;
  endfunction

  // Calibration delay
  logic [CAL_W-1:0] r_calib_cnt;
  logic             r_calib_done;

  always_ff @(posedge i_clk_axi) begin
    if (!i_rstn_axi) begin
      r_calib_cnt  <= '0;
      r_calib_done <= 1'b0;
    end else if (!r_calib_done) begin
      r_calib_cnt <= r_calib_cnt + CAL_W'(1);
      if (r_calib_cnt == CAL_W'(CALIB_CYC - 1)) r_calib_done <= 1'b1;
    end
  end

  assign o_calib_done = r_calib_done;

  // Write channel
  wstate_t           r_wstate, w_wstate_nxt;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wlen, r_wcnt;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst, r_bresp;
  logic [ID_W-1:0]   r_wid, r_bid;
  logic              r_werr, r_wlast_err;
  logic              w_aw_hs, w_w_hs, w_wlast_beat;
  logic [MEM_AW-1:0] w_widx;

  assign w_aw_hs      = i_awvalid && o_awready;
  assign w_w_hs       = i_wvalid && o_wready;
  assign w_wlast_beat = (r_wcnt == r_wlen);
  assign w_widx       = r_waddr[LSB +: MEM_AW];

  always_ff @(posedge i_clk_axi) begin
    if (!i_rstn_axi) r_wstate <= W_IDLE;
    else             r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
      W_RESP:  if (i_bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    o_awready = r_calib_done && (r_wstate == W_IDLE);
    o_wready  = (r_wstate == W_DATA);
    o_bvalid  = (r_wstate == W_RESP);
  end

  always_ff @(posedge i_clk_axi) begin
    if (!i_rstn_axi) begin
      r_waddr     <= '0;
      r_wlen      <= '0;
      r_wcnt      <= '0;
      r_wsize     <= '0;
      r_wburst    <= '0;
      r_wid       <= '0;
      r_werr      <= 1'b0;
      r_wlast_err <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= '0;
    end else begin
      if (w_aw_hs) begin
        r_waddr     <= i_awaddr;
        r_wlen      <= i_awlen;
        r_wsize     <= i_awsize;
        r_wburst    <= i_awburst;
        r_wid       <= i_awid;
        r_wcnt      <= '0;
        r_werr      <= burst_err(i_awlen, i_awsize, i_awburst);
        r_wlast_err <= 1'b0;
      end
      if (w_w_hs) begin
        r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
        r_wcnt  <= r_wcnt + 8'd1;
        if (i_wlast != w_wlast_beat) r_wlast_err <= 1'b1;
        // The final beat's own wlast check folds straight into the response.
        if (w_wlast_beat) begin
          r_bid   <= r_wid;
          r_bresp <= (r_werr || r_wlast_err || !i_wlast) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  assign o_bid   = r_bid;
  assign o_bresp = r_bresp;

  always_ff @(posedge i_clk_axi) begin
    if (i_rstn_axi && w_w_hs && !r_werr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[w_widx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Read channel
  rstate_t           r_rstate, w_rstate_nxt;
  logic [ADDR_W-1:0] r_raddr;
  logic [7:0]        r_rlen, r_rcnt;
  logic [2:0]        r_rsize;
  logic [1:0]        r_rburst, r_rresp;
  logic [ID_W-1:0]   r_rid;
  logic              r_rerr, r_rlast;
  logic [DATA_W-1:0] r_rdata;
  logic [LAT_W-1:0]  r_rwait;
  logic              w_ar_hs, w_r_hs, w_wait_done, w_rload;
  logic [MEM_AW-1:0] w_ridx;

  assign w_ar_hs     = i_arvalid && o_arready;
  assign w_r_hs      = o_rvalid && i_rready;
  assign w_wait_done = (r_rstate == R_WAIT) && (r_rwait == LAT_W'(RD_LAT - 1));
  // A beat loads when the latency expires, or back-to-back with a handshake.
  assign w_rload     = w_wait_done || ((r_rstate == R_DATA) && w_r_hs && !r_rlast);
  assign w_ridx      = r_raddr[LSB +: MEM_AW];

  always_ff @(posedge i_clk_axi) begin
    if (!i_rstn_axi) r_rstate <= R_IDLE;
    else             r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_WAIT;
      R_WAIT:  if (w_wait_done) w_rstate_nxt = R_DATA;
      R_DATA:  if (w_r_hs && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    o_arready = r_calib_done && (r_rstate == R_IDLE);
    o_rvalid  = (r_rstate == R_DATA);
  end

  always_ff @(posedge i_clk_axi) begin
    if (!i_rstn_axi) begin
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rresp  <= '0;
      r_rid    <= '0;
      r_rerr   <= 1'b0;
      r_rlast  <= 1'b0;
      r_rdata  <= '0;
      r_rwait  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_raddr  <= i_araddr;
        r_rlen   <= i_arlen;
        r_rsize  <= i_arsize;
        r_rburst <= i_arburst;
        r_rid    <= i_arid;
        r_rcnt   <= '0;
        r_rwait  <= '0;
        r_rerr   <= burst_err(i_arlen, i_arsize, i_arburst);
        r_rresp  <= burst_err(i_arlen, i_arsize, i_arburst) ? 2'b10 : 2'b00;
      end
      if (r_rstate == R_WAIT) r_rwait <= r_rwait + LAT_W'(1);
      // r_raddr/r_rcnt always describe the next beat to be loaded.
      if (w_rload) begin
        r_rdata <= r_rerr ? '0 : r_mem[w_ridx];
        r_rlast <= (r_rcnt == r_rlen);
        r_raddr <= next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
        r_rcnt  <= r_rcnt + 8'd1;
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_rid   = r_rid;
  assign o_rresp = r_rresp;
  assign o_rlast = r_rlast;

endmodule

// File: tb/tb_axi4_burst_mem_model.sv
// tb/tb_axi4_burst_mem_model.sv - directed self-checking bench for axi4_burst_mem_model
module tb_axi4_burst_mem_model;

  localparam int RD_LAT = 4;
  localparam int CALIB  = 16;

  logic         clk, rstn;
  logic         calib_done;
  logic [26:0]  awaddr, araddr;
  logic         awid, arid, bid, rid;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic         arvalid, arready, rlast, rvalid, rready;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] wbeats [16];
  logic [127:0] rb [16];
  logic [1:0]   rr [16];
  logic         rl [16];
  logic [1:0]   resp;
  logic         bidv;

  axi4_burst_mem_model #(.RD_LAT(RD_LAT), .CALIB_CYC(CALIB)) u_dut (
    .i_clk_axi(clk), .i_rstn_axi(rstn), .o_calib_done(calib_done),
    .i_awaddr(awaddr), .i_awid(awid), .i_awlen(awlen), .i_awsize(awsize),
    .i_awburst(awburst), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_araddr(araddr), .i_arid(arid), .i_arlen(arlen), .i_arsize(arsize),
    .i_arburst(arburst), .i_arvalid(arvalid), .o_arready(arready),
    .o_rdata(rdata), .o_rid(rid), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid),
    .i_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one full write transaction.
  task automatic wr_burst(input logic [26:0] addr, input logic id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [15:0] strb,
                          input int early_last, input int b_delay,
                          output logic [1:0] resp_o, output logic bid_o);
    int n;
    awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("aw_timeout", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbeats[i]; wstrb = strb; wlast = (i == int'(len)) || (i == early_last);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("w_timeout", wready, 1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    for (int d = 0; d < b_delay; d++) begin
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_no_awready", awready, 0);
      @(negedge clk);
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("b_timeout", bvalid, 1);
    resp_o = bresp; bid_o = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Called at a negedge; rready follows pat[cycle % 4]. Beats land in rb/rr/rl.
  task automatic rd_burst(input logic [26:0] addr, input logic id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat);
    int n, k, c, beat;
    logic stalled;
    logic [127:0] held;
    araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ar_timeout", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    k = 0;
    while (!rvalid && k < 200) begin @(negedge clk); k++; end
    chk("r_latency", k, RD_LAT);
    c = 0; beat = 0; stalled = 1'b0; held = '0;
    while (beat <= int'(len) && c < 200) begin
      rready = pat[c % 4];
      if (rvalid) begin
        if (stalled) chk("r_stable", rdata, held);
        if (rready) begin
          chk("r_rid", rid, id);
          rb[beat] = rdata; rr[beat] = rresp; rl[beat] = rlast;
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = rdata;
        end
      end
      @(negedge clk);
      c++;
    end
    if (c >= 200) chk("r_beat_timeout", beat, int'(len) + 1);
    rready = 1'b0;
    chk("r_idle_after_burst", rvalid, 0);
  endtask

  initial begin
    int n, seen;
    rstn = 1'b0;
    awaddr = '0; awid = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
    araddr = '0; arid = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;

    // Reset and calibration
    repeat (3) @(negedge clk);
    chk("rst_ctrl_outputs",
        {calib_done, awready, wready, bid, bresp, bvalid, arready, rid, rresp, rlast, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    rstn = 1'b1;
    repeat (CALIB - 1) @(negedge clk);
    chk("calib_early", {calib_done, awready, arready}, 3'b000);
    @(negedge clk);
    chk("calib_done", {calib_done, awready, arready}, 3'b111);

    // INCR write then read back
    for (int i = 0; i < 4; i++) wbeats[i] = 128'hA0 + i;
    wr_burst(27'h100, 1'b1, 8'd3, 3'd4, 2'b01, 16'hFFFF, -1, 0, resp, bidv);
    chk("incr_bresp", resp, 2'b00);
    chk("incr_bid", bidv, 1);
    rd_burst(27'h100, 1'b1, 8'd3, 3'd4, 2'b01, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rb[i], 128'hA0 + i);
      chk("incr_rlast", rl[i], i == 3);
      chk("incr_rresp", rr[i], 2'b00);
    end

    // WRAP from 0x130 visits 0x130, 0x100, 0x110, 0x120
    rd_burst(27'h130, 1'b0, 8'd3, 3'd4, 2'b10, 4'b1111);
    for (int i = 0; i < 4; i++) chk("wrap_rdata", rb[i], 128'hA0 + ((i + 3) % 4));

    // WRAP with illegal length 3 beats
    rd_burst(27'h100, 1'b0, 8'd2, 3'd4, 2'b10, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_err_rresp", rr[i], 2'b10);
      chk("wrap_err_rdata", rb[i], 0);
      chk("wrap_err_rlast", rl[i], i == 2);
    end

    // Narrow strobe write over an all-ones word
    wbeats[0] = '1;
    wr_burst(27'h200, 1'b0, 8'd0, 3'd4, 2'b01, 16'hFFFF, -1, 0, resp, bidv);
    chk("preload_bresp", resp, 2'b00);
    wbeats[0] = 128'hDEADBEEF;
    wr_burst(27'h200, 1'b0, 8'd0, 3'd4, 2'b01, 16'h000F, -1, 0, resp, bidv);
    chk("narrow_bresp", resp, 2'b00);
    rd_burst(27'h200, 1'b0, 8'd0, 3'd4, 2'b01, 4'b1111);
    chk("narrow_rdata", rb[0], {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEAD_BEEF});
    chk("narrow_rlast", rl[0], 1);

    // Read backpressure 1-0-0-1
    rd_burst(27'h100, 1'b1, 8'd3, 3'd4, 2'b01, 4'b1001);
    for (int i = 0; i < 4; i++) chk("bp_rdata", rb[i], 128'hA0 + i);

    // Write response held while bready low for 5 cycles
    wbeats[0] = 128'hC0;
    wr_burst(27'h400, 1'b0, 8'd0, 3'd4, 2'b01, 16'hFFFF, -1, 5, resp, bidv);
    chk("bhold_bresp", resp, 2'b00);
    chk("bhold_bid", bidv, 0);

    // Early wlast on beat 1 of a 4-beat burst; data still lands
    for (int i = 0; i < 4; i++) wbeats[i] = 128'hB0 + i;
    wr_burst(27'h300, 1'b1, 8'd3, 3'd4, 2'b01, 16'hFFFF, 1, 0, resp, bidv);
    chk("early_wlast_bresp", resp, 2'b10);
    chk("early_wlast_bid", bidv, 1);
    rd_burst(27'h300, 1'b0, 8'd3, 3'd4, 2'b01, 4'b1111);
    for (int i = 0; i < 4; i++) chk("early_wlast_data", rb[i], 128'hB0 + i);

    // Reset in the middle of a read burst
    araddr = 27'h100; arid = 1'b1; arlen = 8'd3; arsize = 3'd4; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 200) begin @(negedge clk); n++; end
    chk("abort_first_rvalid", rvalid, 1);
    rready = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", rvalid, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_arready", arready, 0);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    chk("abort_no_more_beats", seen, 0);
    rready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
